// File: rtl/atm_bill_dispenser.sv
// Bill dispenser responder: feeds one bill per accepted request, waits for the exit sensor, owns the stock count.
// Optional macro ATM_BILL_DISPENSER_SENSE_FILTER_EN adds a synchronizer plus a 2-high qualifier on bill_sense.
module atm_bill_dispenser #(
  parameter int STOCK_W       = 3,
  parameter int STOCK_MAX     = 7,
  parameter int MOTOR_CYCLES  = 4,
  parameter int SENSE_TIMEOUT = 8,
  parameter int CNT_W         = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req,
  input  logic               refill,
  input  logic [STOCK_W-1:0] refill_val,
  input  logic               bill_sense,
  input  logic               fault_clr,
  output logic               motor,
  output logic               busy,
  output logic               ack,
  output logic               nack,
  output logic               fault,
  output logic               empty,
  output logic [STOCK_W-1:0] stock
);

  typedef enum logic [2:0] {
    IDLE, FEED, WAIT_SENSE, DONE, REJECT, FAULT
  } state_e;

  localparam logic [STOCK_W-1:0] SMAX     = STOCK_W'(STOCK_MAX);
  localparam logic [CNT_W-1:0]   MOT_LAST = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SNS_LAST = CNT_W'(SENSE_TIMEOUT - 1);

  state_e             state_q;
  logic [STOCK_W-1:0] stock_q;
  logic [CNT_W-1:0]   timer_q;
  logic               motor_q, ack_q, nack_q;
  logic               sense_ok;

`ifdef ATM_BILL_DISPENSER_SENSE_FILTER_EN
  // [0],[1] synchronizer, [2] previous synchronized sample for the 2-high qualifier
  logic [2:0] sync_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], bill_sense};
  end
  assign sense_ok = sync_q[1] & sync_q[2];
`else
  assign sense_ok = bill_sense;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stock_q <= SMAX;
      timer_q <= '0;
      motor_q <= 1'b0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      nack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // refill has priority; a coincident req is dropped silently
          if (refill) begin
            stock_q <= (refill_val > SMAX) ? SMAX : refill_val;
          end else if (req && stock_q == '0) begin
            state_q <= REJECT;
            nack_q  <= 1'b1;
          end else if (req) begin
            state_q <= FEED;
            timer_q <= '0;
            motor_q <= 1'b1;
          end
        end
        FEED: begin
          if (timer_q == MOT_LAST) begin
            state_q <= WAIT_SENSE;
            timer_q <= '0;
            motor_q <= 1'b0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        WAIT_SENSE: begin
          // sense on the last timeout cycle still wins over the fault
          if (sense_ok) begin
            state_q <= DONE;
            stock_q <= stock_q - STOCK_W'(1);
            ack_q   <= 1'b1;
          end else if (timer_q == SNS_LAST) begin
            state_q <= FAULT;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        DONE, REJECT: state_q <= IDLE;
        FAULT: if (fault_clr) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign motor = motor_q;
  assign ack   = ack_q;
  assign nack  = nack_q;
  assign busy  = (state_q != IDLE);
  assign fault = (state_q == FAULT);
  assign empty = (stock_q == '0);
  assign stock = stock_q;

endmodule

// File: doc/atm_bill_dispenser.md
Name: atm_bill_dispenser

Overview:
- Responder to the cashier's withdrawal pulse. It accepts a one-cycle withdraw request and drives the feed motor for a fixed time.
- It then waits for the bill-exit sensor and returns a one-cycle ack, a nack when empty, or a sticky fault.
- It owns the physical stock count, which starts full at 7 and decrements per bill delivered. It can be reloaded by a service refill.
- Sits between the cashier control FSM (request side) and the mechanism (motor out, sensor in).

Parameters:
STOCK_W, 3, width of stock count
STOCK_MAX, 7, reset/refill ceiling of stock (must be <= 2^STOCK_W-1)
MOTOR_CYCLES, 4, clock cycles motor is held high per bill (>=1)
SENSE_TIMEOUT, 8, max cycles in WAIT_SENSE before fault (>=1)
CNT_W, 4, width of shared timer (must hold max(MOTOR_CYCLES, SENSE_TIMEOUT))

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
req  input  1  withdraw request, single-cycle pulse from cashier FSM
refill  input  1  service reload strobe
refill_val  input  STOCK_W  bills loaded on refill
bill_sense  input  1  exit sensor, high while a bill passes
fault_clr  input  1  service clear of fault
motor  output  1  feed motor drive
busy  output  1  high in any state other than IDLE
ack  output  1  one-cycle pulse: bill delivered
nack  output  1  one-cycle pulse: request rejected, stock empty
fault  output  1  high while in FAULT
empty  output  1  stock == 0 (combinational from stock)
stock  output  STOCK_W  current bill count

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset values:
  - state=IDLE, stock=STOCK_MAX, timer=0.
  - motor=busy=ack=nack=fault=0.
  - empty=0 (assuming STOCK_MAX>0).
- All outputs are registered except empty, busy and fault, which decode directly from state/stock.
- States: IDLE, FEED, WAIT_SENSE, DONE, REJECT, FAULT.
- IDLE:
  - refill=1: stock <= min(refill_val, STOCK_MAX); stay IDLE.
  - else req=1 and stock==0: go to REJECT.
  - else req=1: go to FEED, timer <= 0.
  - refill and req in the same cycle: refill wins, req is dropped (no nack).
- FEED:
  - motor=1 for exactly MOTOR_CYCLES cycles.
  - req is t → motor high t+1 .. t+MOTOR_CYCLES.
  - After the last cycle, go to WAIT_SENSE with timer <= 0.
  - bill_sense is ignored in FEED.
- WAIT_SENSE:
  - motor=0.
  - bill_sense=1: go to DONE and stock <= stock-1 on the same edge.
  - else timer increments. If bill_sense has not been seen in SENSE_TIMEOUT cycles, go to FAULT; stock is unchanged.
  - bill_sense on the final timeout cycle still counts as success.
- DONE: ack=1 for one cycle, then IDLE.
- REJECT: nack=1 for one cycle, then IDLE.
- FAULT:
  - fault=1 held.
  - fault_clr=1: IDLE on the next edge.
  - req and refill are ignored while in FAULT.
- Boundaries:
  - req outside IDLE is ignored; no queuing, no nack.
  - refill outside IDLE is ignored.
  - stock never underflows, since FEED is entered only when stock>0.
  - refill_val > STOCK_MAX saturates to STOCK_MAX.
  - refill_val=0 is legal and makes empty=1.
  - reset mid-operation returns to the reset state immediately; an interrupted bill is not counted.
- Latency: with sense sampled at edge s, ack and the decremented stock are visible in cycle s+1.

Optional Feature:
- Macro: ATM_BILL_DISPENSER_SENSE_FILTER_EN.
- Defined: bill_sense passes through a 2-stage synchronizer plus a 2-consecutive-high qualifier before WAIT_SENSE sees it.
  - This adds 3 cycles of sense latency.
  - A single-cycle glitch is never counted.
  - The timeout counter runs unchanged, so a valid sense must arrive by cycle SENSE_TIMEOUT-3.
- Undefined: raw bill_sense is used directly in WAIT_SENSE, as specified above.

Test Plan (defaults, filter macro undefined):
- Reset, then req at cycle 10; bill_sense high at cycle 16 → motor high cycles 11-14, ack at 17, stock 7→6, busy low from 18.
- 7 successful withdrawals, then req → stock=0 and empty=1; the 8th req gives nack one cycle later; motor never rises.
- req, no bill_sense → fault rises 8 cycles after WAIT_SENSE entry and holds.
  - Further req ignored and stock unchanged.
  - fault_clr → IDLE next cycle, fault=0.
- At stock=2, refill with refill_val=5 → stock=5. Then refill_val=7 → 7. Then refill_val=0 → 0, empty=1 (checks overwrite semantics; with STOCK_W=3 no input can exceed STOCK_MAX=7).
  - Verify saturation in a second run with STOCK_MAX=5: refill_val=7 → stock=5.
- Simultaneous events:
  - refill=1 and req=1 in IDLE → stock reloaded, no FEED.
  - req during FEED → ignored, single ack.
  - bill_sense during FEED only → not counted.
- Assert reset during FEED (motor=1) → motor, busy and ack drop asynchronously; stock returns to 7; next req works normally.
